// File: rtl/tile_line_fetcher.sv
// Background scanline fetcher: walks the tile map, fetches 4bpp pattern rows and streams 8 pixels per tile.
// Optional H/V flip from tile attributes is enabled by defining TILE_LINE_FETCHER_FLIP_EN.
module tile_line_fetcher #(
    parameter int unsigned Bits         = 16,
    parameter int unsigned MapBase      = 0,
    parameter int unsigned PatternBase  = 8192,
    parameter int unsigned TilesPerLine = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lineStart,
    input  logic [7:0]      lineY,
    output logic [Bits-1:0] address,
    input  logic [7:0]      dataIn,
    output logic            busy,
    output logic            pixelValid,
    input  logic            pixelReady,
    output logic [3:0]      pixelColor,
    output logic [1:0]      pixelPalette,
    output logic            lineDone
);

    localparam int unsigned ColW = $clog2(TilesPerLine + 1);

    typedef enum logic [2:0] {IDLE, IDX, ATTR, PAT0, PAT1, PAT2, PAT3, EMIT} state_t;

    state_t          state;
    logic [4:0]      map_row;
    logic [2:0]      fine_y;
    logic [ColW-1:0] column;
    logic [7:0]      tile_idx;
    logic [1:0]      pal;
    logic [23:0]     pat_bytes;
    logic [27:0]     pix_rest;
    logic [2:0]      pix_cnt;

    logic [ColW-1:0] col_next;
    logic [2:0]      row_y;
    logic [Bits-1:0] pat_addr;
    logic [31:0]     row_word;
    logic [31:0]     emit_word;

    function automatic logic [Bits-1:0] map_addr(input logic [4:0] row, input logic [ColW-1:0] col);
        return Bits'(MapBase) + (Bits'(row) << 6) + (Bits'(col) << 1);
    endfunction

    // Pixel 0 sits in the top nibble; reversing nibbles mirrors the tile row.
    function automatic logic [31:0] nib_rev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = w[4*(7-i) +: 4];
        end
        return r;
    endfunction

    assign col_next = column + ColW'(1);
    assign row_word = {pat_bytes, dataIn};

`ifdef TILE_LINE_FETCHER_FLIP_EN
    logic flip_h;
    assign row_y     = dataIn[6] ? ~fine_y : fine_y;
    assign emit_word = flip_h ? nib_rev(row_word) : row_word;
`else
    assign row_y     = fine_y;
    assign emit_word = row_word;
`endif

    // Evaluated in ATTR, where dataIn carries the attribute byte.
    assign pat_addr = Bits'(PatternBase) + (Bits'(tile_idx) << 5) + (Bits'(row_y) << 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            address      <= '0;
            busy         <= 1'b0;
            pixelValid   <= 1'b0;
            pixelColor   <= '0;
            pixelPalette <= '0;
            lineDone     <= 1'b0;
            map_row      <= '0;
            fine_y       <= '0;
            column       <= '0;
            tile_idx     <= '0;
            pal          <= '0;
            pat_bytes    <= '0;
            pix_rest     <= '0;
            pix_cnt      <= '0;
`ifdef TILE_LINE_FETCHER_FLIP_EN
            flip_h       <= 1'b0;
`endif
        end else begin
            lineDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (lineStart) begin
                        map_row <= lineY[7:3];
                        fine_y  <= lineY[2:0];
                        column  <= '0;
                        address <= map_addr(lineY[7:3], '0);
                        busy    <= 1'b1;
                        state   <= IDX;
                    end
                end
                IDX: begin
                    tile_idx <= dataIn;
                    address  <= address + Bits'(1);
                    state    <= ATTR;
                end
                ATTR: begin
                    pal     <= dataIn[1:0];
`ifdef TILE_LINE_FETCHER_FLIP_EN
                    flip_h  <= dataIn[7];
`endif
                    address <= pat_addr;
                    state   <= PAT0;
                end
                PAT0: begin
                    pat_bytes[23:16] <= dataIn;
                    address          <= address + Bits'(1);
                    state            <= PAT1;
                end
                PAT1: begin
                    pat_bytes[15:8] <= dataIn;
                    address         <= address + Bits'(1);
                    state           <= PAT2;
                end
                PAT2: begin
                    pat_bytes[7:0] <= dataIn;
                    address        <= address + Bits'(1);
                    state          <= PAT3;
                end
                PAT3: begin
                    pixelValid   <= 1'b1;
                    pixelColor   <= emit_word[31:28];
                    pix_rest     <= emit_word[27:0];
                    pixelPalette <= pal;
                    pix_cnt      <= '0;
                    state        <= EMIT;
                end
                EMIT: begin
                    if (pixelReady) begin
                        if (pix_cnt == 3'd7) begin
                            pixelValid <= 1'b0;
                            column     <= col_next;
                            if (32'(col_next) < TilesPerLine) begin
                                address <= map_addr(map_row, col_next);
                                state   <= IDX;
                            end else begin
                                busy     <= 1'b0;
                                lineDone <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            pix_cnt    <= pix_cnt + 3'd1;
                            pixelColor <= pix_rest[27:24];
                            pix_rest   <= {pix_rest[23:0], 4'h0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Scoreboard bench for tile_line_fetcher: a RAM array feeds the DUT, a line-level model queues expected
// fetch addresses and pixels, and a negedge monitor compares them as the DUT presents them.
module tb_tile_line_fetcher;

    localparam int TILES    = 32;
    localparam int MAP_BASE = 0;
    localparam int PAT_BASE = 8192;
    localparam int LINE_CYC = TILES * 14;
`ifdef TILE_LINE_FETCHER_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        lineStart;
    logic [7:0]  lineY;
    logic [15:0] address;
    logic [7:0]  dataIn;
    logic        busy;
    logic        pixelValid;
    logic        pixelReady;
    logic [3:0]  pixelColor;
    logic [1:0]  pixelPalette;
    logic        lineDone;

    logic [7:0]  mem [65536];
    logic [15:0] exp_addr [$];
    logic [5:0]  exp_pix [$];

    int checks;
    int failures;
    int pix_acc;
    int stall_cnt;
    bit rand_ready;
    bit stall_req;
    int stall_left;
    bit prev_stall;
    logic [5:0] prev_pix;

    tile_line_fetcher #(
        .Bits(16), .MapBase(MAP_BASE), .PatternBase(PAT_BASE), .TilesPerLine(TILES)
    ) dut (
        .clk(clk), .reset(reset), .lineStart(lineStart), .lineY(lineY),
        .address(address), .dataIn(dataIn), .busy(busy), .pixelValid(pixelValid),
        .pixelReady(pixelReady), .pixelColor(pixelColor), .pixelPalette(pixelPalette),
        .lineDone(lineDone)
    );

    assign dataIn = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: derive the full fetch/pixel stream of one line straight from RAM contents.
    task automatic model_line(input int y);
        int row, fy, ma, pa, idx, ry, k;
        logic [7:0] attr, b;
        logic [3:0] c;
        row = y / 8;
        fy  = y % 8;
        for (int col = 0; col < TILES; col++) begin
            ma = (MAP_BASE + row * 64 + col * 2) % 65536;
            exp_addr.push_back(16'(ma));
            exp_addr.push_back(16'((ma + 1) % 65536));
            idx  = int'(mem[ma]);
            attr = mem[(ma + 1) % 65536];
            ry = (FLIP && attr[6]) ? 7 - fy : fy;
            pa = (PAT_BASE + idx * 32 + ry * 4) % 65536;
            for (int i = 0; i < 4; i++) exp_addr.push_back(16'((pa + i) % 65536));
            for (int p = 0; p < 8; p++) begin
                k = (FLIP && attr[7]) ? 7 - p : p;
                b = mem[(pa + k / 2) % 65536];
                c = (k % 2 == 0) ? b[7:4] : b[3:0];
                exp_pix.push_back({attr[1:0], c});
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic random_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(pixelValid), 32'd0);
        check({tag, "_done"}, 32'(lineDone), 32'd0);
        check({tag, "_addr"}, 32'(address), 32'd0);
        check({tag, "_color"}, 32'(pixelColor), 32'd0);
        check({tag, "_pal"}, 32'(pixelPalette), 32'd0);
    endtask

    // Starts from posedge+1 with the DUT idle; exp_len < 0 means 448 plus observed stall cycles.
    task automatic run_line(input logic [7:0] y, input bit hold_start, input int exp_len);
        int n;
        bit done;
        model_line(int'(y));
        pix_acc   = 0;
        stall_cnt = 0;
        lineY     = y;
        lineStart = 1'b1;
        @(posedge clk);
        #1;
        if (hold_start) lineY = 8'd100;
        else lineStart = 1'b0;
        n = 0;
        done = 1'b0;
        while (n < 3 * LINE_CYC && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (lineDone) done = 1'b1;
        end
        lineStart = 1'b0;
        if (!done) fail_now("line_timeout");
        else check("line_len", 32'(n), 32'((exp_len < 0) ? LINE_CYC + stall_cnt : exp_len));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(lineDone), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("addr_q_empty", 32'(exp_addr.size()), 32'd0);
        check("pix_q_empty", 32'(exp_pix.size()), 32'd0);
        exp_addr.delete();
        exp_pix.delete();
    endtask

    // Ready driver: random or held high, with an optional 5-cycle stall on pixel 3 of the line.
    initial begin
        pixelReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && pix_acc == 3) begin
                stall_req  = 1'b0;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                pixelReady = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                pixelReady = ($urandom_range(3) != 0);
            end else begin
                pixelReady = 1'b1;
            end
        end
    end

    // Monitor: fetch cycles are busy && !pixelValid; pixels are checked on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(pixelValid), 32'd1);
                    check("stall_hold", 32'({pixelPalette, pixelColor}), 32'(prev_pix));
                end
                prev_stall = 1'b0;
                if (busy && !pixelValid) begin
                    if (exp_addr.size() == 0) fail_now("fetch_addr_unexpected");
                    else check("fetch_addr", 32'(address), 32'(exp_addr.pop_front()));
                end
                if (pixelValid) begin
                    if (pixelReady) begin
                        pix_acc++;
                        if (exp_pix.size() == 0) fail_now("pixel_unexpected");
                        else check("pixel", 32'({pixelPalette, pixelColor}), 32'(exp_pix.pop_front()));
                    end else begin
                        stall_cnt++;
                        prev_stall = 1'b1;
                        prev_pix   = {pixelPalette, pixelColor};
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rand_ready = 1'b0;
        stall_req  = 1'b0;
        stall_left = 0;
        prev_stall = 1'b0;
        reset      = 1'b0;
        lineStart  = 1'b0;
        lineY      = 8'd0;
        clear_mem();

        // Reset held with random inputs, then idle after release.
        repeat (4) begin
            @(posedge clk);
            #1;
            lineStart = 1'($urandom);
            lineY     = 8'($urandom);
            #1;
            check_reset_outputs("rst");
        end
        lineStart = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(pixelValid), 32'd0);
            check("idle_done", 32'(lineDone), 32'd0);
            check("idle_addr", 32'(address), 32'd0);
        end

        // Line 0 with mixed flip attributes.
        clear_mem();
        mem[3] = 8'h80; mem[5] = 8'h40; mem[7] = 8'hC1;
        mem[8192] = 8'h0E; mem[8193] = 8'h80; mem[8194] = 8'h88; mem[8195] = 8'h00;
        run_line(8'd0, 1'b0, LINE_CYC);

        // Line 8: tile 1 blank, tile 2 solid colour 1.
        clear_mem();
        mem[64] = 8'h01; mem[66] = 8'h02;
        for (int i = 8256; i < 8288; i++) mem[i] = 8'h11;
        run_line(8'd8, 1'b0, LINE_CYC);

        // Backpressure on pixel 3 adds exactly 5 cycles.
        clear_mem();
        mem[3] = 8'h80; mem[5] = 8'h40; mem[7] = 8'hC1;
        mem[8192] = 8'h0E; mem[8193] = 8'h80; mem[8194] = 8'h88; mem[8195] = 8'h00;
        stall_req = 1'b1;
        run_line(8'd0, 1'b0, LINE_CYC + 5);

        // lineStart held through the line (lineY=100) is ignored, including at the final edge.
        random_mem();
        run_line(8'd37, 1'b1, LINE_CYC);

        // Reset during PAT2 of column 5, then a clean restart.
        model_line(21);
        lineY     = 8'd21;
        lineStart = 1'b1;
        @(posedge clk);
        #1;
        lineStart = 1'b0;
        repeat (5 * 14 + 4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        exp_addr.delete();
        exp_pix.delete();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_line(8'd21, 1'b0, LINE_CYC);

        // Random RAM, random lines, random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            random_mem();
            run_line(8'($urandom), 1'b0, -1);
        end
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
